uart_tx_ctrl: RTL

Frame sequencer for the UART transmit path. It accepts a parallel byte and enables the shift-right serializer for exactly DATA_WIDTH bit-periods. It frames the output with start, optional parity and stop bits, and drives the line through its internal output mux. One bit-period equals one CLK cycle; CLK is already the baud-rate clock.

---
 rtl/uart_tx_pkg.sv | 32 +++
 rtl/uart_tx_parity.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: state encoding, TX_OUT mux selects and parity-type constants
// shared by the UART transmit frame sequencer.
package uart_tx_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MUX_W   = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP2  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    STOP2  = ST_STOP2
  } state_e;

  localparam logic [MUX_W-1:0] MUX_START = 2'd0;
  localparam logic [MUX_W-1:0] MUX_DATA  = 2'd1;
  localparam logic [MUX_W-1:0] MUX_PAR   = 2'd2;
  localparam logic [MUX_W-1:0] MUX_STOP  = 2'd3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: registered parity generator; captures the parity of the
// payload when load_en is high and holds it for the rest of the frame.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  logic par_d;
  logic par_q;

  // Next parity: XOR-reduce of the payload, inverted for odd parity.
  always_comb begin
    par_d = par_q;
    if (load_en) begin
      par_d = (^data) ^ (par_typ == PAR_ODD);
    end
  end

  // Parity latch with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_bit = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer. Frames the serializer's data
// with start, optional parity and stop bits; one bit per CLK cycle.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (STOP, STOP2).
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic [MUX_W-1:0] mux_sel;
  logic             accept_c;
  logic             par_bit;

  uart_tx_parity #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clk     (CLK),
    .rst     (RST),
    .load_en (accept_c),
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit)
  );

  // Moore output decode, acceptance and next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    busy       = 1'b0;
    ser_en     = 1'b0;
    frame_done = 1'b0;
    mux_sel    = MUX_STOP;

    case (state_q)
      START:  begin busy = 1'b1; mux_sel = MUX_START; end
      DATA:   begin busy = 1'b1; ser_en = 1'b1; mux_sel = MUX_DATA; end
      PARITY: begin busy = 1'b1; mux_sel = MUX_PAR; end
`ifdef UART_TX_TWO_STOP_EN
      STOP:   busy = 1'b1;
      STOP2:  frame_done = 1'b1;
`else
      STOP:   frame_done = 1'b1;
`endif
      default: ;
    endcase

    accept_c = Data_Valid & ~busy;
    if (accept_c) begin
      par_en_d = PAR_EN;
    end

    case (state_q)
      IDLE: if (accept_c) state_d = START;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog: serializer never signalled its last bit.
          state_d = STOP;
        end
      end
      PARITY: state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:   state_d = STOP2;
      STOP2:  state_d = accept_c ? START : IDLE;
`else
      STOP:   state_d = accept_c ? START : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Serial line mux; DATA passes the serializer bit straight through.
  always_comb begin
    TX_OUT = 1'b1;
    case (mux_sel)
      MUX_START: TX_OUT = 1'b0;
      MUX_DATA:  TX_OUT = ser_data;
      MUX_PAR:   TX_OUT = par_bit;
      default:   TX_OUT = 1'b1;
    endcase
  end

  // State, watchdog counter and parity-enable latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
    end
  end

endmodule
